// File: rtl/axis_frame_mux.sv
// AXI4-Stream N:1 frame-aware multiplexer: channel switches only happen on a
// start-of-frame (tuser) boundary, and the output passes through a 2-entry skid buffer.
module axis_frame_mux #(
    parameter int WIDTH      = 32,
    parameter int NUM_IN     = 2,
    parameter bit DROP_UNSEL = 1'b1,
    localparam int SEL_W     = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_IN-1:0]       s_axis_tvalid,
    input  logic [NUM_IN-1:0]       s_axis_tuser,
    input  logic [NUM_IN-1:0]       s_axis_tlast,
    output logic [NUM_IN-1:0]       s_axis_tready,
    output logic [WIDTH-1:0]        m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [SEL_W-1:0]        active_ch,
    output logic [15:0]             frame_cnt
);

    typedef enum logic {
        WAIT_SOF,
        PASS
    } state_t;

    localparam int BEAT_W = WIDTH + 2;
    localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];

    state_t            state;
    logic [SEL_W-1:0]  req_ch;
    logic              rdy_en;

    logic [BEAT_W-1:0] buf_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        buf_cnt;

    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_user;
    logic              in_last;
    logic              sel_ok;
    logic              sof_block;
    logic              act_ready;
    logic              accept;
    logic              push;
    logic              pop;

    always_comb begin
        in_data  = '0;
        in_valid = 1'b0;
        in_user  = 1'b0;
        in_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (active_ch == SEL_W'(i)) begin
                in_data  = s_axis_tdata[i*WIDTH +: WIDTH];
                in_valid = s_axis_tvalid[i];
                in_user  = s_axis_tuser[i];
                in_last  = s_axis_tlast[i];
            end
        end
    end

    assign sel_ok = ({1'b0, sel} < NUM_IN_W);

    // A SOF from the old channel while a different one is requested is held
    // off so that the new channel takes over exactly at the frame boundary.
    assign sof_block = (state == PASS) && in_valid && in_user && (req_ch != active_ch);
    assign act_ready = rdy_en && (buf_cnt != 2'd2) && !sof_block;
    assign accept    = in_valid && act_ready;
    assign push      = accept && ((state == PASS) || in_user);
    assign pop       = (buf_cnt != 2'd0) && m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (active_ch == SEL_W'(i)) begin
                s_axis_tready[i] = act_ready;
            end else begin
                s_axis_tready[i] = rdy_en && DROP_UNSEL;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= WAIT_SOF;
            active_ch <= '0;
            req_ch    <= '0;
            frame_cnt <= '0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (sel_ok) begin
                req_ch <= sel;
            end
            case (state)
                WAIT_SOF: begin
                    // Hold the channel on the cycle its SOF is taken so the
                    // rest of that frame comes from the same source.
                    if (accept && in_user) begin
                        state     <= PASS;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        active_ch <= req_ch;
                    end
                end
                PASS: begin
                    if (sof_block) begin
                        state     <= WAIT_SOF;
                        active_ch <= req_ch;
                    end else if (accept && in_user) begin
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: state <= WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_cnt <= '0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= {in_user, in_last, in_data};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Head entry only moves on a pop, which keeps the output stable under stall.
    assign m_axis_tvalid = (buf_cnt != 2'd0);
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = buf_mem[rd_ptr];

endmodule
